memory_access_stage: RTL and testbench
======================================

# memory_access_stage

Pipeline memory stage of the 5-stage core: takes the execute-stage result, performs load/store traffic to a variable-latency data memory port through a two-state request/ack FSM, and registers the result into the MEM/WB pipeline register that feeds the write-back stage's result mux. It stalls the upstream pipeline while a memory access is outstanding. It also performs byte-lane steering for stores and extension for loads.

## Interface
- `WORD_SIZE` (from `constants.v`, 32): datapath width.
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ValidM` input 1: an instruction occupies the M stage this cycle.
- `ALUResultM` input `WORD_SIZE`: effective address or ALU result.
- `WriteDataM` input `WORD_SIZE`: store data (rs2).
- `PCPlus4M` input `WORD_SIZE`: PC+4 of the instruction.
- `RdM` input 5: destination register.
- `RegWriteM` input 1: register-write enable.
- `MemWriteM` input 1: store.
- `ResultSrcM` input 2: 00 ALU, 01 memory load, 10 PC+4; 11 treated as 00.
- `funct3M` input 3: access size/sign.
- `StallM` output 1: hold upstream stages and M inputs this cycle.
- `MisalignedM` output 1: one-cycle pulse, misaligned access dropped.
- `dmem_req` output 1: memory request, registered.
- `dmem_we` output 1: 1 store, 0 load.
- `dmem_addr` output `WORD_SIZE`: word address, {ALUResultM[31:2],2'b00}.
- `dmem_be` output 4: byte enables.
- `dmem_wdata` output `WORD_SIZE`: lane-replicated store data.
- `dmem_ack` input 1: request completed; `dmem_rdata` valid same cycle.
- `dmem_rdata` input `WORD_SIZE`: raw load word.
- `ALUResultW`, `ReadDataW`, `PCPlus4W` output `WORD_SIZE`; `RdW` output 5; `RegWriteW` output 1; `ResultSrcW` output 2: MEM/WB register contents.

## Operation
- Memory op: ValidM & (MemWriteM | ResultSrcM==01). Non-memory ops pass through in one cycle, StallM=0.
- Alignment: halfword (funct3[1:0]=01) needs addr[0]=0; word (10) needs addr[1:0]=00; bytes always aligned. Misaligned memory op: no request, MisalignedM=1 for that cycle, StallM=0, W register loads a bubble (RegWriteW=0, RdW=0).
- FSM states IDLE, WAIT. IDLE + aligned memory op: StallM=1; at edge register dmem_req=1, we, addr, be, wdata; go WAIT. WAIT: dmem_req and all dmem_* outputs held stable; StallM=!dmem_ack; on dmem_ack: dmem_req=0 at edge, return IDLE, W register captures the instruction with ReadDataW formatted from dmem_rdata.
- dmem_ack in IDLE ignored.
- Store lanes: sb be=0001<<addr[1:0], wdata={4{data[7:0]}}; sh be=0011<<addr[1:0], wdata={2{data[15:0]}}; sw be=1111, wdata=data. Loads: be=1111.
- Load format, byte select by addr[1:0]: lb 000 sign-extend, lbu 100 zero-extend, lh 001 sign, lhu 101 zero, lw 010 full word. Other funct3 values: treated as lw/sw.
- Stores: RegWriteW forced 0. Non-memory ops: ReadDataW=0.
- W register update: loads new values whenever StallM=0; ValidM=0 or misalignment → bubble; StallM=1 → W loads bubble (RegWriteW=0) so no instruction retires twice.

## Timing
- Reset: state IDLE; dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0; all W outputs 0; StallM=0, MisalignedM=0. Reset during WAIT abandons the access; later ack ignored.
- Non-memory op in M at cycle n: visible on W outputs at n+1.
- Memory op at cycle n: dmem_req high from n+1; ack at cycle n+k (k≥1) → W outputs at n+k+1; StallM high cycles n..n+k-1.
- StallM and MisalignedM combinational from state, inputs, dmem_ack.

## Test plan
- Reset then addi (ResultSrcM=00, ALUResultM=0x5, RdM=3) -> next cycle ALUResultW=0x5, RdW=3, RegWriteW=1, StallM never high.
- lb addr 0x103, dmem_rdata=0x80FF_0000 with ack 3 cycles after req -> StallM high 3 cycles, req held stable, dmem_addr=0x100, ReadDataW=0xFFFF_FF80.
- sh addr 0x202, WriteDataM=0x1234_ABCD, ack immediate -> dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, RegWriteW=0, StallM high exactly 1 cycle.
- lw addr 0x301 -> MisalignedM=1 one cycle, dmem_req stays 0, W bubble RegWriteW=0.
- lhu addr 0x402, rdata=0x8001_0000 -> ReadDataW=0x0000_8001; back-to-back sw follows with ack 1 cycle -> second request issued cycle after first retires.
- rst asserted during WAIT, ack arrives next cycle -> dmem_req=0, state IDLE, no W update from the ack, all W outputs 0.

Source files
------------

// File: rtl/memory_access_stage.sv
// Pipeline M stage: issues load/store requests to a variable-latency data port,
// steers store byte lanes, formats load data and registers the MEM/WB contents.
//
// state | meaning
// IDLE  | no access outstanding; non-memory ops flow straight to W
// WAIT  | request held on dmem_*; upstream stalled until dmem_ack
module memory_access_stage #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ValidM,
    input  logic [WORD_SIZE-1:0] ALUResultM,
    input  logic [WORD_SIZE-1:0] WriteDataM,
    input  logic [WORD_SIZE-1:0] PCPlus4M,
    input  logic [4:0]           RdM,
    input  logic                 RegWriteM,
    input  logic                 MemWriteM,
    input  logic [1:0]           ResultSrcM,
    input  logic [2:0]           funct3M,
    output logic                 StallM,
    output logic                 MisalignedM,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [WORD_SIZE-1:0] dmem_addr,
    output logic [3:0]           dmem_be,
    output logic [WORD_SIZE-1:0] dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [WORD_SIZE-1:0] dmem_rdata,
    output logic [WORD_SIZE-1:0] ALUResultW,
    output logic [WORD_SIZE-1:0] ReadDataW,
    output logic [WORD_SIZE-1:0] PCPlus4W,
    output logic [4:0]           RdW,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t               stateQ, stateD;
    logic                 memOp, sizeByte, sizeHalf, misaligned, issue;
    logic [3:0]           reqBe;
    logic [WORD_SIZE-1:0] reqWdata, loadData;
    logic [7:0]           ldByte;
    logic [15:0]          ldHalf;
    logic [1:0]           resultSrcEff;

    always_comb begin
        memOp        = ValidM & (MemWriteM | (ResultSrcM == 2'b01));
        // funct3 codes outside the legal set for the op type fall back to word access
        sizeByte     = (funct3M == 3'b000) | (!MemWriteM & (funct3M == 3'b100));
        sizeHalf     = (funct3M == 3'b001) | (!MemWriteM & (funct3M == 3'b101));
        misaligned   = memOp & ((sizeHalf & ALUResultM[0]) |
                                (!sizeByte & !sizeHalf & (ALUResultM[1:0] != 2'b00)));
        issue        = (stateQ == IDLE) & memOp & !misaligned;
        resultSrcEff = (ResultSrcM == 2'b11) ? 2'b00 : ResultSrcM;

        stateD      = stateQ;
        StallM      = 1'b0;
        MisalignedM = 1'b0;
        case (stateQ)
            IDLE: begin
                MisalignedM = misaligned;
                if (issue) begin
                    StallM = 1'b1;
                    stateD = WAIT;
                end
            end
            WAIT: begin
                StallM = !dmem_ack;
                if (dmem_ack) stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase

        reqBe    = 4'b1111;
        reqWdata = WriteDataM;
        if (MemWriteM && sizeByte) begin
            reqBe    = 4'b0001 << ALUResultM[1:0];
            reqWdata = {4{WriteDataM[7:0]}};
        end else if (MemWriteM && sizeHalf) begin
            reqBe    = 4'b0011 << ALUResultM[1:0];
            reqWdata = {2{WriteDataM[15:0]}};
        end

        case (ALUResultM[1:0])
            2'b00:   ldByte = dmem_rdata[7:0];
            2'b01:   ldByte = dmem_rdata[15:8];
            2'b10:   ldByte = dmem_rdata[23:16];
            default: ldByte = dmem_rdata[31:24];
        endcase
        ldHalf = ALUResultM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3M)
            3'b000:  loadData = {{(WORD_SIZE-8){ldByte[7]}}, ldByte};
            3'b100:  loadData = {{(WORD_SIZE-8){1'b0}}, ldByte};
            3'b001:  loadData = {{(WORD_SIZE-16){ldHalf[15]}}, ldHalf};
            3'b101:  loadData = {{(WORD_SIZE-16){1'b0}}, ldHalf};
            default: loadData = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ     <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= 5'd0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
        end else begin
            stateQ <= stateD;
            if (issue) begin
                dmem_req   <= 1'b1;
                dmem_we    <= MemWriteM;
                dmem_addr  <= {ALUResultM[WORD_SIZE-1:2], 2'b00};
                dmem_be    <= reqBe;
                dmem_wdata <= reqWdata;
            end else if ((stateQ == WAIT) && dmem_ack) begin
                dmem_req <= 1'b0;
            end

            // Stalled cycles retire a bubble so the held instruction never retires twice
            if (!StallM && (stateQ == WAIT)) begin
                ALUResultW <= ALUResultM;
                ReadDataW  <= MemWriteM ? '0 : loadData;
                PCPlus4W   <= PCPlus4M;
                RdW        <= RdM;
                RegWriteW  <= RegWriteM & !MemWriteM;
                ResultSrcW <= resultSrcEff;
            end else if (!StallM && ValidM && !memOp) begin
                ALUResultW <= ALUResultM;
                ReadDataW  <= '0;
                PCPlus4W   <= PCPlus4M;
                RdW        <= RdM;
                RegWriteW  <= RegWriteM;
                ResultSrcW <= resultSrcEff;
            end else begin
                ALUResultW <= '0;
                ReadDataW  <= '0;
                PCPlus4W   <= '0;
                RdW        <= 5'd0;
                RegWriteW  <= 1'b0;
                ResultSrcW <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: single-cycle vector table plus
// hand-written multi-cycle access sequences.
module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic        StallM, MisalignedM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    memory_access_stage #(.WORD_SIZE(32)) dut (
        .clk(clk), .rst(rst), .ValidM(ValidM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .funct3M(funct3M), .StallM(StallM), .MisalignedM(MisalignedM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .PCPlus4W(PCPlus4W), .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
    );

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic        expMis;
        logic        expRetire;
        logic [4:0]  expRd;
        logic [1:0]  expRs;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic setOp(input logic valid, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] pc4, input logic [4:0] rd, input logic rw,
                         input logic mw, input logic [1:0] rs, input logic [2:0] f3);
        ValidM = valid; ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc4; RdM = rd;
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; funct3M = f3;
    endtask

    // Called right after the op is driven in its first M cycle; ack arrives k cycles later.
    task automatic runAccess(input int k, input logic [31:0] rdata, output int stallCycles,
                             output logic stable, output logic [31:0] addr0,
                             output logic [3:0] be0, output logic [31:0] wd0, output logic we0);
        stallCycles = 0;
        stable = 1'b1;
        addr0 = '0; be0 = '0; wd0 = '0; we0 = 1'b0;
        for (int c = 0; c <= k; c++) begin
            dmem_ack   = (c == k);
            dmem_rdata = (c == k) ? rdata : 32'hDEAD_BEEF;
            @(negedge clk);
            if (StallM) stallCycles++;
            if (c == 1) begin
                addr0 = dmem_addr; be0 = dmem_be; wd0 = dmem_wdata; we0 = dmem_we;
            end
            if (c >= 1 && (dmem_req !== 1'b1 || dmem_addr !== addr0 || dmem_be !== be0 ||
                           dmem_wdata !== wd0 || dmem_we !== we0))
                stable = 1'b0;
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
    endtask

    int          sc;
    logic        st, we0;
    logic [31:0] a0, wd0;
    logic [3:0]  be0;

    initial begin
        //                valid alu         wd    pc4       rd rw mw rs     f3      mis ret  rd  rs
        vecs[0] = '{1'b1, 32'h5,    32'h0,  32'h10, 5'd3, 1, 0, 2'b00, 3'b000, 0, 1, 5'd3, 2'b00};
        vecs[1] = '{1'b1, 32'h1234, 32'h0,  32'h48, 5'd1, 1, 0, 2'b10, 3'b000, 0, 1, 5'd1, 2'b10};
        vecs[2] = '{1'b1, 32'h77,   32'h0,  32'h50, 5'd7, 1, 0, 2'b11, 3'b000, 0, 1, 5'd7, 2'b00};
        vecs[3] = '{1'b1, 32'h301,  32'h0,  32'h54, 5'd4, 1, 0, 2'b01, 3'b010, 1, 0, 5'd0, 2'b00};
        vecs[4] = '{1'b1, 32'h105,  32'h0,  32'h58, 5'd5, 1, 0, 2'b01, 3'b001, 1, 0, 5'd0, 2'b00};
        vecs[5] = '{1'b1, 32'h302,  32'hAA, 32'h5C, 5'd0, 0, 1, 2'b00, 3'b010, 1, 0, 5'd0, 2'b00};
        vecs[6] = '{1'b0, 32'h300,  32'hAA, 32'h60, 5'd6, 1, 1, 2'b00, 3'b010, 0, 0, 5'd0, 2'b00};
        vecs[7] = '{1'b1, 32'h3,    32'h0,  32'h64, 5'd8, 1, 0, 2'b01, 3'b101, 1, 0, 5'd0, 2'b00};
        vecs[8] = '{1'b1, 32'h102,  32'h0,  32'h68, 5'd9, 1, 0, 2'b01, 3'b011, 1, 0, 5'd0, 2'b00};

        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
        setOp(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_w_bus", {ALUResultW ^ ReadDataW ^ PCPlus4W, 27'd0, RdW}, 0);
        chk("rst_w_ctl", {RegWriteW, ResultSrcW}, 0);
        @(negedge clk);
        chk("rst_stall", StallM, 0);
        chk("rst_mis", MisalignedM, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            setOp(vecs[i].valid, vecs[i].alu, vecs[i].wd, vecs[i].pc4, vecs[i].rd,
                  vecs[i].rw, vecs[i].mw, vecs[i].rs, vecs[i].f3);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), StallM, 0);
            chk($sformatf("v%0d_mis", i), MisalignedM, vecs[i].expMis);
            @(posedge clk); #1;
            chk($sformatf("v%0d_req", i), dmem_req, 0);
            chk($sformatf("v%0d_rdw", i), RdW, vecs[i].expRd);
            chk($sformatf("v%0d_regw", i), RegWriteW, vecs[i].expRetire);
            chk($sformatf("v%0d_rdata", i), ReadDataW, 0);
            if (vecs[i].expRetire) begin
                chk($sformatf("v%0d_alu", i), ALUResultW, vecs[i].alu);
                chk($sformatf("v%0d_pc4", i), PCPlus4W, vecs[i].pc4);
                chk($sformatf("v%0d_rs", i), ResultSrcW, vecs[i].expRs);
            end
        end

        // lb from byte 3, ack in the third request cycle
        setOp(1, 32'h103, 32'h0, 32'h70, 5'd10, 1, 0, 2'b01, 3'b000);
        runAccess(3, 32'h80FF_0000, sc, st, a0, be0, wd0, we0);
        setOp(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000);
        chk("lb_stall_cycles", sc, 3);
        chk("lb_req_stable", st, 1);
        chk("lb_addr", a0, 32'h100);
        chk("lb_be", be0, 4'b1111);
        chk("lb_we", we0, 0);
        chk("lb_rdata", ReadDataW, 32'hFFFF_FF80);
        chk("lb_rd", RdW, 10);
        chk("lb_regw", RegWriteW, 1);
        chk("lb_req_drop", dmem_req, 0);

        // sh to upper half with immediate ack; RegWriteM deliberately 1 to see it masked
        setOp(1, 32'h202, 32'h1234_ABCD, 32'h74, 5'd11, 1, 1, 2'b00, 3'b001);
        runAccess(1, 32'h0, sc, st, a0, be0, wd0, we0);
        setOp(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000);
        chk("sh_stall_cycles", sc, 1);
        chk("sh_be", be0, 4'b1100);
        chk("sh_wdata", wd0, 32'hABCD_ABCD);
        chk("sh_we", we0, 1);
        chk("sh_addr", a0, 32'h200);
        chk("sh_regw", RegWriteW, 0);

        // sb to lane 1
        setOp(1, 32'h201, 32'h0000_005A, 32'h78, 5'd0, 0, 1, 2'b00, 3'b000);
        runAccess(2, 32'h0, sc, st, a0, be0, wd0, we0);
        setOp(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000);
        chk("sb_be", be0, 4'b0010);
        chk("sb_wdata", wd0, 32'h5A5A_5A5A);
        chk("sb_stall_cycles", sc, 2);

        // lhu then back-to-back sw
        setOp(1, 32'h402, 32'h0, 32'h80, 5'd12, 1, 0, 2'b01, 3'b101);
        runAccess(2, 32'h8001_0000, sc, st, a0, be0, wd0, we0);
        chk("lhu_rdata", ReadDataW, 32'h0000_8001);
        chk("lhu_stable", st, 1);
        chk("lhu_req_drop", dmem_req, 0);
        setOp(1, 32'h500, 32'hCAFE_F00D, 32'h84, 5'd0, 0, 1, 2'b00, 3'b010);
        runAccess(1, 32'h0, sc, st, a0, be0, wd0, we0);
        setOp(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000);
        chk("sw_stall_cycles", sc, 1);
        chk("sw_addr", a0, 32'h500);
        chk("sw_wdata", wd0, 32'hCAFE_F00D);
        chk("sw_be", be0, 4'b1111);
        chk("sw_stable", st, 1);

        // reset while waiting, ack arrives afterwards
        setOp(1, 32'h600, 32'h0, 32'h90, 5'd13, 1, 0, 2'b01, 3'b010);
        @(posedge clk); #1;
        chk("rw_req_up", dmem_req, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ValidM = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
        chk("rw_req_rst", dmem_req, 0);
        @(negedge clk);
        chk("rw_stall_ack", StallM, 0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("rw_req_after", dmem_req, 0);
        chk("rw_regw", RegWriteW, 0);
        chk("rw_rd", RdW, 0);
        chk("rw_rdata", ReadDataW, 0);
        chk("rw_alu", ALUResultW, 0);
        chk("rw_pc4", PCPlus4W, 0);
        @(posedge clk); #1;
        chk("rw_req_idle", dmem_req, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
